// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter/sequencer for the unified memory bus
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_byteen,
  output logic             d_gnt,
  output logic             d_done,
  output logic [WIDTH-1:0] d_rdata,
  output logic             bus_mem_read,
  output logic             bus_mem_write,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [3:0]       bus_byteen,
  input  logic [WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_t           state_q, state_d;
  logic             owner_d_q, owner_d_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       byteen_q, byteen_d;
  logic [3:0]       streak_q, streak_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic in_access, in_resp, d_win, commit;

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // Data has priority until it has won MAX_D_STREAK times over a waiting fetch.
  assign d_win  = d_req && !(if_req && (streak_q == MAX_STREAK));
  assign commit = !in_access && (if_req || d_req);

  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byteen_d   = byteen_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ACCESS:  state_d = RESP;
      default: state_d = commit ? ACCESS : IDLE;
    endcase

    if (commit) begin
      owner_d_d = d_win;
      we_d      = d_win && d_we;
      addr_d    = d_win ? d_addr : if_addr;
      wdata_d   = d_win ? d_wdata : '0;
      byteen_d  = d_win ? d_byteen : 4'b0000;
      if (d_win && if_req)
        streak_d = (streak_q == MAX_STREAK) ? streak_q : streak_q + 4'd1;
      else
        streak_d = 4'd0;
    end

    if (in_resp && !owner_d_q)
      if_rdata_d = bus_rdata;
    if (in_resp && owner_d_q && !we_q)
      d_rdata_d = bus_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= 4'b0000;
      streak_q   <= 4'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_gnt        = in_access && !owner_d_q;
  assign d_gnt         = in_access && owner_d_q;
  assign bus_mem_read  = in_access && !(owner_d_q && we_q);
  assign bus_mem_write = in_access && owner_d_q && we_q;
  assign if_rvalid     = in_resp && !owner_d_q;
  assign d_done        = in_resp && owner_d_q;

  // Read data is live from the bus in RESP and holds its last value otherwise.
  assign if_rdata   = (in_resp && !owner_d_q) ? bus_rdata : if_rdata_q;
  assign d_rdata    = (in_resp && owner_d_q && !we_q) ? bus_rdata : d_rdata_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_byteen = byteen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int W    = 32;
  localparam int MAXS = 4;
  localparam int N    = 600;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [W-1:0]  if_addr;
  logic          if_gnt, if_rvalid;
  logic [W-1:0]  if_rdata;
  logic          d_req, d_we;
  logic [W-1:0]  d_addr, d_wdata;
  logic [3:0]    d_byteen;
  logic          d_gnt, d_done;
  logic [W-1:0]  d_rdata;
  logic          bus_mem_read, bus_mem_write;
  logic [W-1:0]  bus_addr, bus_wdata;
  logic [3:0]    bus_byteen;
  logic [W-1:0]  bus_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.WIDTH(W), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .bus_mem_read(bus_mem_read), .bus_mem_write(bus_mem_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_if_gnt"}, if_gnt, 0);
    chk({pfx, "_if_rvalid"}, if_rvalid, 0);
    chk({pfx, "_if_rdata"}, if_rdata, 0);
    chk({pfx, "_d_gnt"}, d_gnt, 0);
    chk({pfx, "_d_done"}, d_done, 0);
    chk({pfx, "_d_rdata"}, d_rdata, 0);
    chk({pfx, "_rd"}, bus_mem_read, 0);
    chk({pfx, "_wr"}, bus_mem_write, 0);
    chk({pfx, "_addr"}, bus_addr, 0);
    chk({pfx, "_wdata"}, bus_wdata, 0);
    chk({pfx, "_byteen"}, bus_byteen, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference schedule: 0 none, 1 IF access, 2 D access, 3 IF resp, 4 D resp
  int            sk[N+3];
  logic [W-1:0]  sa[N+3];
  logic [W-1:0]  sw[N+3];
  logic [3:0]    sb[N+3];
  logic          swe[N+3];

  initial begin
    string        seq;
    logic         flag;
    logic         if_pend, d_pend, dw;
    int           streak;
    logic [W-1:0] br, exp_if_rd, exp_d_rd;

    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; d_byteen = 0; bus_rdata = 0;
    #1;
    chk_all_zero("reset");
    cyc(); cyc();
    rst_n = 1'b1;

    // Single fetch
    if_req = 1; if_addr = 32'h0000_0010;
    cyc();
    chk("fetch_if_gnt", if_gnt, 1);
    chk("fetch_rd", bus_mem_read, 1);
    chk("fetch_addr", bus_addr, 32'h10);
    chk("fetch_d_gnt", d_gnt, 0);
    if_req = 0; bus_rdata = 32'h1234_5678;
    cyc();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h1234_5678);
    chk("fetch_d_done", d_done, 0);
    chk("fetch_resp_rd", bus_mem_read, 0);
    cyc();
    chk("fetch_rvalid_off", if_rvalid, 0);
    chk("fetch_rdata_hold", if_rdata, 32'h1234_5678);

    // Store, then a load to the same address raised during the store's RESP
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_byteen = 4'b0011;
    cyc();
    chk("st_d_gnt", d_gnt, 1);
    chk("st_wr", bus_mem_write, 1);
    chk("st_rd", bus_mem_read, 0);
    chk("st_byteen", bus_byteen, 4'b0011);
    chk("st_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("st_addr", bus_addr, 32'h2000);
    d_we = 0;
    cyc();
    chk("st_done", d_done, 1);
    chk("st_resp_wr", bus_mem_write, 0);
    cyc();
    chk("ld_d_gnt", d_gnt, 1);
    chk("ld_rd", bus_mem_read, 1);
    chk("ld_wr", bus_mem_write, 0);
    chk("ld_addr", bus_addr, 32'h2000);
    d_req = 0; bus_rdata = 32'hCAFE_F00D;
    cyc();
    chk("ld_done", d_done, 1);
    chk("ld_rdata", d_rdata, 32'hCAFE_F00D);
    chk("ld_if_rdata_hold", if_rdata, 32'h1234_5678);
    cyc();

    // Contention: D first, IF access two cycles later
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h3000;
    cyc();
    chk("cont_d_gnt", d_gnt, 1);
    chk("cont_if_gnt0", if_gnt, 0);
    d_req = 0;
    cyc();
    cyc();
    chk("cont_if_gnt", if_gnt, 1);
    chk("cont_d_gnt0", d_gnt, 0);
    chk("cont_if_addr", bus_addr, 32'h40);
    if_req = 0;
    cyc(); cyc();

    // Starvation: both held continuously
    if_req = 1; d_req = 1; seq = ""; flag = 0;
    for (int i = 0; i < 22; i++) begin
      cyc();
      if (if_gnt && d_gnt) flag = 1;
      if (d_gnt) seq = {seq, "D"};
      if (if_gnt) seq = {seq, "I"};
    end
    if_req = 0; d_req = 0;
    checks++;
    assert (seq == "DDDDIDDDDID") else begin
      failures++;
      $error("FAIL starve_seq observed=%s expected=DDDDIDDDDID", seq);
    end
    chk("no_dual_gnt", flag, 0);
    cyc(); cyc();

    // Reset during the ACCESS of a load
    d_req = 1; d_we = 0; d_addr = 32'h44;
    cyc();
    chk("rstmid_d_gnt", d_gnt, 1);
    rst_n = 0;
    #1;
    chk_all_zero("rstmid");
    d_req = 0;
    cyc();
    rst_n = 1;
    flag = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (d_done || d_gnt) flag = 1;
    end
    chk("rstmid_no_done", flag, 0);
    if_req = 1; if_addr = 32'h80;
    cyc();
    chk("post_rst_if_gnt", if_gnt, 1);
    chk("post_rst_addr", bus_addr, 32'h80);
    if_req = 0;
    cyc();
    chk("post_rst_rvalid", if_rvalid, 1);

    // Idle bus
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus_mem_read || bus_mem_write || if_gnt || d_gnt || if_rvalid || d_done) flag = 1;
    end
    chk("idle_quiet", flag, 0);

    // Randomized traffic against a cycle-scheduled reference
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < N + 3; i++) begin
      sk[i] = 0; sa[i] = 0; sw[i] = 0; sb[i] = 0; swe[i] = 0;
    end
    if_pend = 0; d_pend = 0; streak = 0; exp_if_rd = 0; exp_d_rd = 0;

    for (int k = 0; k < N; k++) begin
      br = $urandom;
      bus_rdata = br;
      if (sk[k] == 3) if_pend = 0;
      if (sk[k] == 4) d_pend = 0;
      if (!if_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          if_pend = 1; if_req = 1; if_addr = $urandom;
        end else if_req = 0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 1) == 0) begin
          d_pend = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = $urandom; d_wdata = $urandom; d_byteen = 4'($urandom_range(0, 15));
        end else d_req = 0;
      end
      #1;
      if (sk[k] == 3) exp_if_rd = br;
      if (sk[k] == 4 && !swe[k]) exp_d_rd = br;
      chk($sformatf("rnd%0d_if_gnt", k), if_gnt, W'(sk[k] == 1));
      chk($sformatf("rnd%0d_d_gnt", k), d_gnt, W'(sk[k] == 2));
      chk($sformatf("rnd%0d_if_rvalid", k), if_rvalid, W'(sk[k] == 3));
      chk($sformatf("rnd%0d_d_done", k), d_done, W'(sk[k] == 4));
      chk($sformatf("rnd%0d_rd", k), bus_mem_read, W'(sk[k] == 1 || (sk[k] == 2 && !swe[k])));
      chk($sformatf("rnd%0d_wr", k), bus_mem_write, W'(sk[k] == 2 && swe[k]));
      if (sk[k] == 1 || sk[k] == 2) chk($sformatf("rnd%0d_addr", k), bus_addr, sa[k]);
      if (sk[k] == 2) begin
        chk($sformatf("rnd%0d_wdata", k), bus_wdata, sw[k]);
        chk($sformatf("rnd%0d_byteen", k), bus_byteen, sb[k]);
      end
      chk($sformatf("rnd%0d_if_rdata", k), if_rdata, exp_if_rd);
      chk($sformatf("rnd%0d_d_rdata", k), d_rdata, exp_d_rd);

      // A new access may start on the edge ending any cycle that is not an access cycle.
      if (sk[k] != 1 && sk[k] != 2 && (if_req || d_req)) begin
        dw = d_req && !(if_req && streak == MAXS);
        streak = (dw && if_req) ? streak + 1 : 0;
        sk[k+1] = dw ? 2 : 1;
        sk[k+2] = dw ? 4 : 3;
        sa[k+1] = dw ? d_addr : if_addr;
        sw[k+1] = d_wdata;
        sb[k+1] = d_byteen;
        swe[k+1] = dw && d_we;
        swe[k+2] = dw && d_we;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
